// File: rtl/mem_resp_axi.sv
// mem_resp_axi: bridges a simple req/addr_ok/data_ok memory initiator onto
// AXI read and write channels, with exactly one transaction in flight.
// Ports:
//   clk, reset (async, active-high)
//   initiator side : req, we, size, addr, wstrb, wdata -> addr_ok, data_ok, rdata
//   AXI AR         : araddr, arsize, arvalid / arready
//   AXI R          : r_data, rvalid / rready
//   AXI AW         : awaddr, awsize, awvalid / awready
//   AXI W          : w_data, w_strb, wvalid / wready
//   AXI B          : bvalid / bready (response code not used)
module mem_resp_axi (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] r_data,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [2:0]  awsize,
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] w_data,
    output logic [3:0]  w_strb,
    output logic        wvalid,
    input  logic        wready,
    input  logic        bvalid,
    output logic        bready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_ADDR = 3'd1,
        S_RD_DATA = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic [31:0] r_addr;
    logic [2:0]  r_size;
    logic [3:0]  r_wstrb;
    logic [31:0] r_wdata;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_bready;
    logic        r_aw_done;
    logic        r_w_done;

    logic        w_addr_ok;
    logic        w_aw_fire;
    logic        w_w_fire;
    logic        w_wr_all_done;

    // Acceptance is held off while reset is high even though state reads IDLE.
    assign w_addr_ok = req && (r_state == S_IDLE) && !reset;

    assign w_aw_fire     = r_awvalid && awready;
    assign w_w_fire      = r_wvalid && wready;
    // Both halves done, counting a handshake that completes this very cycle.
    assign w_wr_all_done = (r_aw_done || w_aw_fire) && (r_w_done || w_w_fire);

    assign addr_ok = w_addr_ok;
    assign data_ok = ((r_state == S_RD_DATA) && rvalid) ||
                     ((r_state == S_WR_RESP) && bvalid);
    assign rdata   = r_data;

    // AXI payloads come only from the captured request, never the live inputs.
    assign araddr  = r_addr;
    assign arsize  = r_size;
    assign awaddr  = r_addr;
    assign awsize  = r_size;
    assign w_data  = r_wdata;
    assign w_strb  = r_wstrb;
    assign arvalid = r_arvalid;
    assign rready  = r_rready;
    assign awvalid = r_awvalid;
    assign wvalid  = r_wvalid;
    assign bready  = r_bready;

    // Transaction FSM with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= 32'd0;
            r_size    <= 3'd0;
            r_wstrb   <= 4'd0;
            r_wdata   <= 32'd0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_addr_ok) begin
                        r_addr  <= addr;
                        // Reserved size code 3 is sent as a word.
                        r_size  <= (size == 2'd3) ? 3'd2 : {1'b0, size};
                        r_wstrb <= wstrb;
                        r_wdata <= wdata;
                        if (we) begin
                            r_state   <= S_WR_REQ;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RD_ADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                S_WR_REQ: begin
                    if (w_wr_all_done) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= S_WR_RESP;
                    end else begin
                        if (w_aw_fire) begin
                            r_awvalid <= 1'b0;
                            r_aw_done <= 1'b1;
                        end
                        if (w_w_fire) begin
                            r_wvalid <= 1'b0;
                            r_w_done <= 1'b1;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_resp_axi.sv
// Directed bench for mem_resp_axi with a response scoreboard.
module tb_mem_resp_axi;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready;
    logic [31:0] r_data;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic [2:0]  awsize;
    logic        awvalid;
    logic        awready;
    logic [31:0] w_data;
    logic [3:0]  w_strb;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;

    typedef struct {
        bit          is_load;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_dok = 0;

    always #5 clk = ~clk;

    mem_resp_axi dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .araddr(araddr), .arsize(arsize), .arvalid(arvalid),
        .arready(arready), .r_data(r_data), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
        .w_data(w_data), .w_strb(w_strb), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bready(bready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every data_ok must match the oldest issued request.
    always @(negedge clk) begin
        if (!reset && data_ok) begin
            n_dok++;
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $error("FAIL sb_unexpected data_ok observed=1 expected=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                if (e.is_load) chk("sb_rdata", rdata, e.data);
            end
        end
    end

    initial begin
        int dok0;
        reset = 1'b1; req = 1'b1; we = 1'b0; size = 2'd0; addr = 32'h0;
        wstrb = 4'h0; wdata = 32'h0; arready = 1'b0; r_data = 32'h0;
        rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bvalid = 1'b0;

        // Reset state
        #3;
        chk("rst_addr_ok", 32'(addr_ok), 32'd0);
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_handshakes", 32'({arvalid, awvalid, wvalid, rready, bready}), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        cyc(); cyc();
        reset = 1'b0; req = 1'b0;

        // Basic load
        cyc();
        req = 1'b1; we = 1'b0; addr = 32'h1C00_0004; size = 2'd2;
        #1 chk("ld_addr_ok", 32'(addr_ok), 32'd1);
        chk("ld_no_dok_c0", 32'(data_ok), 32'd0);
        q.push_back('{1'b1, 32'hDEAD_BEEF});
        cyc();
        req = 1'b0; arready = 1'b1;
        #1 chk("ld_arvalid", 32'(arvalid), 32'd1);
        chk("ld_araddr", araddr, 32'h1C00_0004);
        chk("ld_arsize", 32'(arsize), 32'd2);
        chk("ld_busy_addr_ok", 32'(addr_ok), 32'd0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'hDEAD_BEEF;
        #1 chk("ld_rready", 32'(rready), 32'd1);
        chk("ld_data_ok", 32'(data_ok), 32'd1);
        chk("ld_arvalid_off", 32'(arvalid), 32'd0);
        cyc();
        rvalid = 1'b0;
        #1 chk("ld_rready_off", 32'(rready), 32'd0);
        chk("ld_dok_off", 32'(data_ok), 32'd0);

        // Store: wready first, awready two cycles later
        cyc();
        req = 1'b1; we = 1'b1; addr = 32'h8000_0002; size = 2'd1;
        wstrb = 4'b1100; wdata = 32'h1234_1234;
        #1 chk("st_addr_ok", 32'(addr_ok), 32'd1);
        q.push_back('{1'b0, 32'h0});
        cyc();
        req = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0; wstrb = 4'h0; wready = 1'b1;
        #1 chk("st_valids_c1", 32'({awvalid, wvalid}), 32'b11);
        chk("st_awaddr", awaddr, 32'h8000_0002);
        chk("st_awsize", 32'(awsize), 32'd1);
        chk("st_wdata", w_data, 32'h1234_1234);
        chk("st_wstrb", 32'(w_strb), 32'hC);
        cyc();
        wready = 1'b0;
        #1 chk("st_valids_c2", 32'({awvalid, wvalid}), 32'b10);
        cyc();
        awready = 1'b1;
        #1 chk("st_valids_c3", 32'({awvalid, wvalid}), 32'b10);
        chk("st_bready_c3", 32'(bready), 32'd0);
        cyc();
        awready = 1'b0;
        #1 chk("st_c4_state", 32'({awvalid, wvalid, bready, data_ok}), 32'b0010);
        cyc();
        bvalid = 1'b1;
        #1 chk("st_data_ok", 32'(data_ok), 32'd1);
        cyc();
        bvalid = 1'b0;
        #1 chk("st_bready_off", 32'(bready), 32'd0);

        // Back-to-back loads with req held high
        cyc();
        req = 1'b1; we = 1'b0; addr = 32'h0000_0100; size = 2'd0;
        #1 chk("b2b_addr_ok1", 32'(addr_ok), 32'd1);
        q.push_back('{1'b1, 32'hA5A5_0001});
        cyc();
        arready = 1'b1;
        #1 chk("b2b_busy1", 32'(addr_ok), 32'd0);
        cyc();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'hA5A5_0001;
        addr = 32'h0000_0200; size = 2'd1;
        #1 chk("b2b_dok1", 32'(data_ok), 32'd1);
        chk("b2b_busy2", 32'(addr_ok), 32'd0);
        cyc();
        rvalid = 1'b0;
        #1 chk("b2b_addr_ok2", 32'(addr_ok), 32'd1);
        q.push_back('{1'b1, 32'h5A5A_0002});
        cyc();
        req = 1'b0; arready = 1'b1;
        #1 chk("b2b_araddr2", araddr, 32'h0000_0200);
        chk("b2b_arsize2", 32'(arsize), 32'd1);
        cyc();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'h5A5A_0002;
        #1 chk("b2b_dok2", 32'(data_ok), 32'd1);
        cyc();
        rvalid = 1'b0;

        // arready stall: payload held, live addr and stray rvalid/bvalid ignored
        cyc();
        req = 1'b1; we = 1'b0; addr = 32'h0000_3000; size = 2'd3;
        #1 chk("stall_addr_ok", 32'(addr_ok), 32'd1);
        q.push_back('{1'b1, 32'h0BAD_F00D});
        for (int i = 0; i < 5; i++) begin
            cyc();
            req = 1'b0; addr = $urandom; rvalid = 1'b1; bvalid = 1'b1;
            #1 chk("stall_arvalid", 32'(arvalid), 32'd1);
            chk("stall_araddr", araddr, 32'h0000_3000);
            chk("stall_arsize", 32'(arsize), 32'd2);
            chk("stall_stray", 32'({data_ok, rready, bready}), 32'd0);
        end
        cyc();
        rvalid = 1'b0; bvalid = 1'b0; arready = 1'b1;
        #1 chk("stall_arvalid_hs", 32'(arvalid), 32'd1);
        cyc();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'h0BAD_F00D;
        #1 chk("stall_dok", 32'(data_ok), 32'd1);
        cyc();
        rvalid = 1'b0;

        // Reset in RD_DATA before rvalid
        cyc();
        req = 1'b1; we = 1'b0; addr = 32'h0000_4444; size = 2'd2;
        #1 chk("rstmid_addr_ok", 32'(addr_ok), 32'd1);
        cyc();
        req = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0;
        #1 chk("rstmid_rready", 32'(rready), 32'd1);
        dok0 = n_dok;
        reset = 1'b1;
        #1 chk("rstmid_async", 32'({arvalid, awvalid, wvalid, rready, bready, data_ok}), 32'd0);
        rvalid = 1'b1; r_data = 32'h7777_7777;
        #1 chk("rstmid_rvalid_ign", 32'(data_ok), 32'd0);
        cyc(); cyc();
        reset = 1'b0; req = 1'b1; addr = 32'h0000_4000;
        #1 chk("rstmid_accept", 32'(addr_ok), 32'd1);
        chk("rstmid_no_dok", 32'(data_ok), 32'd0);
        q.push_back('{1'b1, 32'h4000_CAFE});
        cyc();
        req = 1'b0; rvalid = 1'b0; arready = 1'b1;
        cyc();
        arready = 1'b0; rvalid = 1'b1; r_data = 32'h4000_CAFE;
        #1 chk("rstmid_dok_new", 32'(data_ok), 32'd1);
        cyc();
        rvalid = 1'b0;
        #1 chk("rstmid_dok_count", 32'(n_dok - dok0), 32'd1);

        // Simultaneous awready/wready on first WR_REQ cycle
        cyc();
        req = 1'b1; we = 1'b1; addr = 32'h0000_5000; size = 2'd0;
        wstrb = 4'b0001; wdata = 32'hAAAA_AAAA;
        #1 chk("sim_addr_ok", 32'(addr_ok), 32'd1);
        q.push_back('{1'b0, 32'h0});
        dok0 = n_dok;
        cyc();
        req = 1'b0; awready = 1'b1; wready = 1'b1;
        #1 chk("sim_valids", 32'({awvalid, wvalid}), 32'b11);
        cyc();
        awready = 1'b0; wready = 1'b0;
        #1 chk("sim_wr_resp", 32'({awvalid, wvalid, bready}), 32'b001);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1 chk("sim_wait", 32'({bready, data_ok}), 32'b10);
        end
        cyc();
        bvalid = 1'b1;
        #1 chk("sim_dok", 32'(data_ok), 32'd1);
        cyc();
        bvalid = 1'b0;
        #1 chk("sim_bready_off", 32'(bready), 32'd0);
        cyc();
        #1 chk("sim_dok_once", 32'(n_dok - dok0), 32'd1);
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
